// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: multi-cycle reverse double-dabble BCD -> binary converter.
// Define BCD_CHECK_EN to flag input nibbles above 9 and force bin_out to 0.
module bcd_to_binary_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  bcd_err
);

  localparam int W    = 4 * DIGITS;
  localparam int ITER = W;
  localparam int CW   = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [W-1:0]    bcd_q;
  logic [W-1:0]    bin_q;
  logic [W-1:0]    bcd_nxt;
  logic [W-1:0]    bin_nxt;
  logic [CW-1:0]   cnt;
  logic [BIN_W-1:0] res;
  logic [BIN_W-1:0] bin_r;
  logic            last;
  logic            err_q;

  assign last = (cnt == CW'(ITER - 1));

  // result keeps the low BIN_W bits of the binary shift register
  generate
    if (BIN_W <= W) begin : g_trunc
      assign res = bin_nxt[BIN_W-1:0];
    end else begin : g_ext
      assign res = {{(BIN_W - W){1'b0}}, bin_nxt};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = SHIFT;
      SHIFT:   if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    bin_out   = bin_r;
  end

  // one shift plus per-digit correction per cycle
  always_comb begin
    {bcd_nxt, bin_nxt} = {bcd_q, bin_q} >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_nxt[4*i +: 4] >= 4'd8)
        bcd_nxt[4*i +: 4] = bcd_nxt[4*i +: 4] - 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q <= '0;
      bin_q <= '0;
      cnt   <= '0;
      bin_r <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            bcd_q <= bcd_in;
            bin_q <= '0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_nxt;
          bin_q <= bin_nxt;
          cnt   <= cnt + 1'b1;
          if (last) bin_r <= err_q ? '0 : res;
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_CHECK_EN
  logic err_in;

  always_comb begin
    err_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) err_in = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if (state == IDLE && in_valid)
      err_q <= err_in;
  end

  assign bcd_err = err_q & out_valid;
`else
  assign err_q   = 1'b0;
  assign bcd_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb_bcd_to_binary_seq: directed + sweep bench with an accept-time scoreboard.
// Expected values come from a decimal model of the BCD nibbles.
module tb_bcd_to_binary_seq;

  localparam int ITER = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] bcd_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  bin_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        bcd_err;

  typedef struct {
    int unsigned val;
    bit          err;
    bit          chk;
  } exp_t;

  exp_t sb[$];
  int   cmps = 0;
  int   errs = 0;
  int   cycle = 0;
  int   acc_edge = -100;
  int   gap = 0;
  bit   prev_ov = 1'b0;
  bit   rnd = 1'b0;

  bcd_to_binary_seq #(.DIGITS(3), .BIN_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd_in    (bcd_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_out   (bin_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_err   (bcd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [11:0] v);
    exp_t e;
    int   d;
    e.val = 0;
    e.err = 1'b0;
    e.chk = 1'b1;
    for (int i = 2; i >= 0; i--) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) e.err = 1'b1;
      e.val = e.val * 10 + d;
    end
`ifdef BCD_CHECK_EN
    if (e.err) e.val = 0;
`else
    if (e.err) e.chk = 1'b0;
    e.err = 1'b0;
`endif
    return e;
  endfunction

  // monitor: push on accept, pop and compare on output handshake
  always @(negedge clk) begin : mon
    exp_t e;
    cycle++;
    if (rst) begin
      sb.delete();
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        sb.push_back(model(bcd_in));
        if (acc_edge >= 0) gap = cycle + 1 - acc_edge;
        acc_edge = cycle + 1;
      end
      if (out_valid && !prev_ov)
        chk("latency", cycle - acc_edge, ITER);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", {31'd0, out_valid}, 0);
        end else begin
          e = sb.pop_front();
          if (e.chk) chk("bin_out", {22'd0, bin_out}, e.val);
          chk("bcd_err", {31'd0, bcd_err}, {31'd0, e.err});
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] v);
    int g = 0;
    bcd_in   = v;
    in_valid = 1'b1;
    while (!in_ready && g < 300) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      step();
      g++;
    end
    chk("accept_timeout", {31'd0, in_ready}, 1);
    if (rnd) out_ready = 1'($urandom_range(0, 1));
    step();
    in_valid = 1'b0;
    chk("in_ready_busy", {31'd0, in_ready}, 0);
  endtask

  task automatic drain();
    int g = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && g < 300) begin
      step();
      g++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    int          g;
    logic [11:0] b;

    repeat (3) step();
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_bin_out", {22'd0, bin_out}, 0);
    chk("rst_bcd_err", {31'd0, bcd_err}, 0);
    rst = 1'b0;
    step();

    send(12'h255);
    drain();

    out_ready = 1'b1;
    send(12'h999);
    send(12'h000);
    chk("accept_gap", gap, ITER + 2);
    drain();

    out_ready = 1'b0;
    send(12'h042);
    g = 0;
    while (!out_valid && g < 50) begin
      step();
      g++;
    end
    bcd_in   = 12'h777;
    in_valid = 1'b1;
    repeat (5) begin
      step();
      chk("bp_valid", {31'd0, out_valid}, 1);
      chk("bp_hold", {22'd0, bin_out}, 42);
      chk("bp_ready", {31'd0, in_ready}, 0);
    end
    out_ready = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    drain();

    out_ready = 1'b0;
    send(12'h123);
    repeat (5) step();
    rst = 1'b1;
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 1);
    chk("abort_out_valid", {31'd0, out_valid}, 0);
    chk("abort_bin_out", {22'd0, bin_out}, 0);
    chk("abort_bcd_err", {31'd0, bcd_err}, 0);
    step();
    step();
    rst = 1'b0;
    step();
    send(12'h123);
    drain();

    send(12'h2A5);
    drain();

    rnd = 1'b1;
    for (int v = 0; v < 1000; v++) begin
      b = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      send(b);
    end
    rnd = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
Multi-cycle converter from packed BCD digits to an unsigned binary value. It is the inverse of the score display path. It turns keypad- or display-formatted decimal entries (e.g. a target score or difficulty entered as digits) back into binary for game logic. It uses reverse double-dabble (shift right, subtract 3 from any digit >= 8) with valid/ready handshakes on both sides.

Parameters:
DIGITS, 3, number of BCD digits accepted (ITER = 4*DIGITS shift iterations)
BIN_W, 10, output width; must satisfy 2^BIN_W > 10^DIGITS - 1 (default covers 0..999)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
bcd_in  input  4*DIGITS  packed BCD, most significant digit in the top nibble
in_valid  input  1  bcd_in is valid
in_ready  output  1  block can accept a conversion (high only in IDLE)
bin_out  output  BIN_W  converted binary value, stable while out_valid
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
bcd_err  output  1  input held a nibble > 9 (see Optional Feature); qualified by out_valid

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, bin_out=0, bcd_err=0, iteration counter=0, shift registers cleared. Deassertion takes effect at the next clk edge.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On edge with in_valid=1: latch bcd_in into BCD shift reg, clear binary shift reg (4*DIGITS bits), counter=0, go to SHIFT. in_valid=0 -> stay.
- SHIFT: in_ready=0, out_valid=0. Each edge:
  - Shift the concatenation {bcd_reg, bin_reg} right by 1 (bcd LSB into bin MSB, 0 into bcd MSB).
  - Then, for each 4-bit digit of the shifted bcd_reg: if value >= 8, subtract 3.
  - Combine shift and correction in one cycle; counter increments.
  - On the edge where counter reaches ITER-1, load bin_out from bin_reg result (low BIN_W bits, upper bits discarded) and go to DONE.
- Latency: out_valid rises exactly ITER edges after the accepting edge (12 for DIGITS=3).
- DONE: out_valid=1, bin_out and bcd_err held stable. On edge with out_ready=1 -> IDLE (out_valid=0, in_ready=1 next cycle). out_ready=0 -> hold indefinitely.
- No overlap: a new input is never accepted in SHIFT or DONE. in_valid there is ignored and not buffered; the source must hold it until in_ready.
- Minimum period between accepted inputs: ITER+2 cycles when out_ready is tied high.
- out_ready in IDLE/SHIFT: ignored.
- Reset mid-SHIFT or mid-DONE: conversion abandoned, no out_valid pulse, return to IDLE reset values.
- All-zero input yields 0. All-9s input yields 10^DIGITS - 1.

Optional Feature:
BCD_CHECK_EN:
- Defined: at accept, any nibble of bcd_in > 9 sets the latched error flag. The conversion still runs the full ITER cycles (latency unchanged). In DONE, bcd_err=1 and bin_out is forced to 0.
- Not defined: no check. bcd_err is tied 0, and invalid nibbles are processed through the same algorithm. The result is undefined but deterministic.

Test Plan:
- Reset, then bcd_in=12'h255, in_valid 1 cycle -> in_ready low next cycle; out_valid exactly 12 edges later with bin_out=255 (0x0FF), bcd_err=0.
- bcd_in=12'h999 then 12'h000, out_ready tied 1 -> bin_out=999 then 0; second accept no earlier than 14 cycles after first.
- Backpressure: convert 12'h042, hold out_ready=0 for 5 cycles while driving in_valid=1 with 12'h777 -> bin_out stays 42, out_valid stays 1, 777 not accepted until after handshake, then yields 777.
- BCD_CHECK_EN defined, bcd_in=12'h2A5 -> after 12 cycles out_valid=1, bcd_err=1, bin_out=0. Without the macro -> bcd_err=0.
- Assert rst on the 6th SHIFT cycle of a 12'h123 conversion -> outputs immediately at reset values, no out_valid. Next input 12'h123 -> 123 with full 12-cycle latency.
- Sweep all 1000 valid 3-digit inputs with random out_ready -> bin_out matches decimal value for every case.
